// File: rtl/condiciona_sensores_if.sv
// rtl/condiciona_sensores_if.sv - field-input bundle between raw sensors and the conditioner
// master drives the raw inputs; slave (the conditioner) returns conditioned values and flags.
interface condiciona_sensores_if;
  logic [6:0] sens_raw;
  logic [6:0] sens_out;
  logic       mudou;
  logic       erro_nivel;

  modport master (output sens_raw, input sens_out, mudou, erro_nivel);
  modport slave  (input sens_raw, output sens_out, mudou, erro_nivel);
endinterface

// File: rtl/condiciona_sensores.sv
// rtl/condiciona_sensores.sv - sync, debounce, level-probe check and change pulse for field inputs
// Optional COND_HOLD_NIVEL_EN: sens_out[6:4] shows the last valid {H,M,L} instead of the raw debounced one.
module condiciona_sensores #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ERR_CYCLES      = 250000,
  parameter int CNT_W           = 18
) (
  input  logic                  clock,
  input  logic                  reset_n,
  condiciona_sensores_if.slave  bus
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ERR_LAST = CNT_W'(ERR_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OK,
    ST_SUSPEITO,
    ST_ERRO,
    ST_RECUPERA
  } state_t;

  // {H,M,L}: a wetted upper probe implies every probe below it is wetted too
  function automatic logic lvl_valid(input logic [2:0] v);
    return !(v[2] && !v[1]) && !(v[1] && !v[0]);
  endfunction

  logic [6:0]            s1_q, s1_d;
  logic [6:0]            s2_q, s2_d;
  logic [6:0]            stable_q, stable_d;
  logic [6:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                  mudou_q, mudou_d;
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      ecnt_q, ecnt_d;
  logic                  erro_q, erro_d;
  logic                  invalid;

  always_comb begin
    s1_d     = bus.sens_raw;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 7; i++) begin
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          stable_d[i] = s2_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
    mudou_d = |(stable_d ^ stable_q);
  end

  // The FSM judges the pre-edge debounced levels, so it lags a debounced update by one cycle
  always_comb begin
    state_d = state_q;
    ecnt_d  = ecnt_q;
    invalid = !lvl_valid(stable_q[6:4]);
    case (state_q)
      ST_OK: begin
        if (invalid) begin
          state_d = ST_SUSPEITO;
          ecnt_d  = CNT_W'(1);
        end else begin
          ecnt_d = '0;
        end
      end
      ST_SUSPEITO: begin
        if (!invalid) begin
          state_d = ST_OK;
          ecnt_d  = '0;
        end else if (ecnt_q >= ERR_LAST) begin
          state_d = ST_ERRO;
          ecnt_d  = '0;
        end else begin
          ecnt_d = ecnt_q + 1'b1;
        end
      end
      ST_ERRO: begin
        if (!invalid) begin
          state_d = ST_RECUPERA;
          ecnt_d  = CNT_W'(1);
        end
      end
      ST_RECUPERA: begin
        if (invalid) begin
          state_d = ST_ERRO;
          ecnt_d  = '0;
        end else if (ecnt_q >= ERR_LAST) begin
          state_d = ST_OK;
          ecnt_d  = '0;
        end else begin
          ecnt_d = ecnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_OK;
        ecnt_d  = '0;
      end
    endcase
    erro_d = (state_q == ST_ERRO) || (state_q == ST_RECUPERA);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      mudou_q  <= 1'b0;
      state_q  <= ST_OK;
      ecnt_q   <= '0;
      erro_q   <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      mudou_q  <= mudou_d;
      state_q  <= state_d;
      ecnt_q   <= ecnt_d;
      erro_q   <= erro_d;
    end
  end

`ifdef COND_HOLD_NIVEL_EN
  logic [2:0] nivel_ok_q, nivel_ok_d;

  always_comb begin
    nivel_ok_d = nivel_ok_q;
    if (lvl_valid(stable_d[6:4])) nivel_ok_d = stable_d[6:4];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) nivel_ok_q <= '0;
    else          nivel_ok_q <= nivel_ok_d;
  end

  assign bus.sens_out = {nivel_ok_q, stable_q[3:0]};
`else
  assign bus.sens_out = stable_q;
`endif

  assign bus.mudou      = mudou_q;
  assign bus.erro_nivel = erro_q;

endmodule
